// File: rtl/coef_loader_pkg.sv
// Shared constants and state encoding for the flash coefficient loader.
// The image magic byte, default flash location and FSM states are defined here.
package coef_loader_pkg;

  localparam logic [7:0]  MAGIC             = 8'hA5;
  localparam logic [23:0] DEFAULT_BASE_ADDR = 24'h0F0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/coef_loader_if.sv
// EPCS read port plus coefficient write port of the loader.
// The master side is the loader; the slave side is flash controller plus coefficient RAM.
interface coef_loader_if #(
  parameter int MAX_COEF = 32
);
  localparam int IDX_W = $clog2(MAX_COEF);

  logic                    epcs_rd;
  logic [23:0]             epcs_addr;
  logic                    epcs_busy;
  logic [7:0]              epcs_rdata;
  logic                    coef_we;
  logic [IDX_W-1:0]        coef_idx;
  logic signed [15:0]      coef_data;

  modport master (
    output epcs_rd, epcs_addr, coef_we, coef_idx, coef_data,
    input  epcs_busy, epcs_rdata
  );

  modport slave (
    input  epcs_rd, epcs_addr, coef_we, coef_idx, coef_data,
    output epcs_busy, epcs_rdata
  );

endinterface

// File: rtl/coef_loader.sv
// Reads a checksummed coefficient image from EPCS flash one byte at a time
// and streams the assembled 16-bit signed coefficients to a write port.
module coef_loader
  import coef_loader_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          MAX_COEF  = 32,
  parameter int          TIMEOUT   = 1023
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          done,
  output logic          error,
  coef_loader_if.master bus
);

  localparam int         IDX_W = $clog2(MAX_COEF);
  localparam logic [9:0] TMO   = 10'(TIMEOUT);
  localparam logic [8:0] MAX_N = 9'(MAX_COEF);

  state_t                  state;
  logic                    busy_q;
  logic [9:0]              tmo_cnt;
  logic [23:0]             offset;
  logic [7:0]              rbyte;
  logic [7:0]              lo_byte;
  logic [7:0]              csum;
  logic [7:0]              n_coef;
  logic [IDX_W-1:0]        coef_num;
  logic                    rd_r;
  logic                    we_r;
  logic [23:0]             addr_r;
  logic [IDX_W-1:0]        idx_r;
  logic signed [15:0]      data_r;
  logic                    busy_fall;
  logic [23:0]             last_off;

  assign busy_fall = busy_q & ~bus.epcs_busy;
  // Checksum byte sits after magic, count and 2N coefficient bytes.
  assign last_off  = {15'd0, n_coef, 1'b0} + 24'd2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy_q   <= 1'b0;
      tmo_cnt  <= '0;
      offset   <= '0;
      rbyte    <= '0;
      lo_byte  <= '0;
      csum     <= '0;
      n_coef   <= '0;
      coef_num <= '0;
      rd_r     <= 1'b0;
      we_r     <= 1'b0;
      addr_r   <= BASE_ADDR;
      idx_r    <= '0;
      data_r   <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      rd_r   <= 1'b0;
      we_r   <= 1'b0;
      busy_q <= bus.epcs_busy;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            done     <= 1'b0;
            error    <= 1'b0;
            offset   <= '0;
            addr_r   <= BASE_ADDR;
            csum     <= '0;
            coef_num <= '0;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (!bus.epcs_busy) begin
            rd_r    <= 1'b1;
            tmo_cnt <= '0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (busy_fall) begin
            rbyte <= bus.epcs_rdata;
            state <= S_CHECK;
          end else if (tmo_cnt == TMO) begin
            error <= 1'b1;
            state <= S_ERR;
          end else begin
            tmo_cnt <= tmo_cnt + 10'd1;
          end
        end
        S_CHECK: begin
          if (offset == 24'd0 && rbyte != MAGIC) begin
            error <= 1'b1;
            state <= S_ERR;
          end else if (offset == 24'd1 && (rbyte == 8'd0 || {1'b0, rbyte} > MAX_N)) begin
            error <= 1'b1;
            state <= S_ERR;
          end else if (offset >= 24'd2 && offset == last_off) begin
            if (rbyte == csum) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              error <= 1'b1;
              state <= S_ERR;
            end
          end else begin
            csum <= csum + rbyte;
            if (offset == 24'd1) n_coef <= rbyte;
            // Even offsets from 2 carry the low byte, odd ones complete a coefficient.
            if (offset >= 24'd2) begin
              if (!offset[0]) begin
                lo_byte <= rbyte;
              end else begin
                we_r     <= 1'b1;
                data_r   <= $signed({rbyte, lo_byte});
                idx_r    <= coef_num;
                coef_num <= coef_num + 1'b1;
              end
            end
            offset <= offset + 24'd1;
            addr_r <= BASE_ADDR + offset + 24'd1;
            state  <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.epcs_rd   = rd_r;
  assign bus.epcs_addr = addr_r;
  assign bus.coef_we   = we_r;
  assign bus.coef_idx  = idx_r;
  assign bus.coef_data = data_r;

endmodule

// File: tb/tb_coef_loader.sv
// Bench for coef_loader: behavioural EPCS flash model, table of images,
// scoreboard of expected coefficient writes, plus timeout and reset sequences.
module tb_coef_loader;
  import coef_loader_pkg::*;

  localparam logic [23:0] BASE = 24'h0F0000;
  localparam int          TMO  = 1023;
  localparam int          LAT  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic done;
  logic error;

  coef_loader_if #(.MAX_COEF(32)) bus();

  coef_loader #(.BASE_ADDR(BASE), .MAX_COEF(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done), .error(error), .bus(bus)
  );

  always #5 clk = ~clk;

  // Flash model: busy rises the cycle after epcs_rd, falls LAT cycles later with data.
  logic [7:0] mem [0:127];
  int         hang_off = -1;
  logic       mdl_busy = 1'b0;
  logic [7:0] mdl_data = 8'h00;
  int         pend     = 0;
  int         raddr    = 0;

  assign bus.epcs_busy  = mdl_busy;
  assign bus.epcs_rdata = mdl_data;

  always @(posedge clk) begin
    if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1) begin
        mdl_busy <= 1'b0;
        mdl_data <= mem[raddr];
      end
    end else if (bus.epcs_rd) begin
      mdl_busy <= 1'b1;
      raddr    <= int'(bus.epcs_addr - BASE);
      pend     <= (int'(bus.epcs_addr - BASE) == hang_off) ? 1100 : LAT;
    end
  end

  typedef struct {
    logic [63:0] img;
    int          len;
    int          exp_rd;
    int          exp_we;
    bit          exp_done;
    bit          exp_err;
    string       name;
  } vec_t;

  vec_t        vecs [6];
  logic [20:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rd_in_load = 0;
  int          we_seen = 0;
  int          rd_cycle = 0;
  int          end_cyc = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic tick();
    logic [20:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.epcs_rd) begin
      chk("rd address", int'(bus.epcs_addr), int'(BASE) + rd_in_load);
      chk("rd while busy", int'(bus.epcs_busy), 0);
      rd_in_load++;
      rd_cycle = cyc;
    end
    if (bus.coef_we) begin
      we_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected coef_we idx", int'(bus.coef_idx), -1);
      end else begin
        e = exp_q.pop_front();
        chk("coef_idx", int'(bus.coef_idx), int'(e[20:16]));
        chk("coef_data", int'(bus.coef_data), int'($signed(e[15:0])));
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
  endtask

  task automatic push_coefs(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({5'(k), mem[3 + 2 * k], mem[2 + 2 * k]});
  endtask

  task automatic run_load(input string name, input int exp_rd, input int exp_we,
                          input bit exp_done, input bit exp_err, input int start_at);
    bit fin;
    rd_in_load = 0;
    we_seen    = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    fin = 1'b0;
    for (int n = 0; n < 5000 && !fin; n++) begin
      if (n == start_at) start = 1'b1;
      tick();
      start = 1'b0;
      fin = done | error;
    end
    end_cyc = cyc;
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL %s completion: no done/error within 5000 cycles", name);
    end
    repeat (3) tick();
    chk({name, " done"}, int'(done), int'(exp_done));
    chk({name, " error"}, int'(error), int'(exp_err));
    chk({name, " rd count"}, rd_in_load, exp_rd);
    chk({name, " we count"}, we_seen, exp_we);
    chk({name, " pending writes"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    logic [7:0]  sum;
    logic [15:0] d;
    int          diff;

    // Good image: 0x65 is the mod-256 sum of A5,02,34,12,CD,AB.
    vecs[0] = '{64'hA5_02_34_12_CD_AB_65_00, 7, 7, 2, 1'b1, 1'b0, "good"};
    vecs[1] = '{64'h5A_02_34_12_CD_AB_65_00, 7, 1, 0, 1'b0, 1'b1, "bad magic"};
    vecs[2] = '{64'hA5_21_00_00_00_00_00_00, 2, 2, 0, 1'b0, 1'b1, "count 33"};
    vecs[3] = '{64'hA5_02_34_12_CD_AB_6C_00, 7, 7, 2, 1'b0, 1'b1, "bad checksum"};
    vecs[4] = '{64'hA5_00_00_00_00_00_00_00, 2, 2, 0, 1'b0, 1'b1, "count 0"};
    vecs[5] = '{64'hA5_01_FF_80_25_00_00_00, 5, 5, 1, 1'b1, 1'b0, "negative coef"};

    clear_mem();
    repeat (3) tick();
    chk("reset epcs_rd", int'(bus.epcs_rd), 0);
    chk("reset coef_we", int'(bus.coef_we), 0);
    chk("reset done", int'(done), 0);
    chk("reset error", int'(error), 0);
    chk("reset epcs_addr", int'(bus.epcs_addr), int'(BASE));
    chk("reset coef_idx", int'(bus.coef_idx), 0);
    chk("reset coef_data", int'(bus.coef_data), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int v = 0; v < 6; v++) begin
      clear_mem();
      for (int i = 0; i < vecs[v].len; i++) mem[i] = vecs[v].img[63 - 8 * i -: 8];
      push_coefs(vecs[v].exp_we);
      run_load(vecs[v].name, vecs[v].exp_rd, vecs[v].exp_we,
               vecs[v].exp_done, vecs[v].exp_err, -1);
    end

    // Full MAX_COEF image; a second start mid-load must be ignored.
    clear_mem();
    mem[0] = 8'hA5;
    mem[1] = 8'd32;
    for (int k = 0; k < 32; k++) begin
      d = 16'(k * 16'h1357) ^ 16'h8000;
      mem[2 + 2 * k] = d[7:0];
      mem[3 + 2 * k] = d[15:8];
    end
    sum = 8'h00;
    for (int i = 0; i < 66; i++) sum = sum + mem[i];
    mem[66] = sum;
    push_coefs(32);
    run_load("count 32", 67, 32, 1'b1, 1'b0, 40);

    // Flash stalls on byte 3: loader must give up after TIMEOUT cycles.
    clear_mem();
    for (int i = 0; i < 7; i++) mem[i] = vecs[0].img[63 - 8 * i -: 8];
    hang_off = 3;
    run_load("timeout", 4, 0, 1'b0, 1'b1, -1);
    diff = end_cyc - rd_cycle;
    checks++;
    if (diff < TMO || diff > TMO + 2) begin
      errors++;
      $display("FAIL timeout latency: got %0d cycles want %0d..%0d", diff, TMO, TMO + 2);
    end
    hang_off = -1;

    // Reset while waiting on a read, then reload from the start.
    rd_in_load = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 2000 && rd_in_load < 3; n++) tick();
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midreset epcs_rd", int'(bus.epcs_rd), 0);
    chk("midreset done", int'(done), 0);
    chk("midreset error", int'(error), 0);
    chk("midreset epcs_addr", int'(bus.epcs_addr), int'(BASE));
    chk("midreset coef_idx", int'(bus.coef_idx), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    rd_in_load = 0;
    repeat (10) tick();
    chk("idle after reset rd", rd_in_load, 0);
    chk("idle after reset done", int'(done), 0);
    push_coefs(2);
    run_load("after reset", 7, 2, 1'b1, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
